// File: rtl/button_conditioner.sv
// Conditions raw push-buttons for the timer control logic. Each channel gets
// a two-flop synchroniser and a four-state debounce FSM. The FSM produces a
// debounced level, single-cycle press/release pulses and a long-hold flag.
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold,
    output logic               any_press
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

    // Count value at which the next stable sample completes the debounce window
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        CHK_PRESS,
        PRESSED,
        CHK_RELEASE
    } state_t;

    logic [NUM_BTN-1:0] sync_a;
    logic [NUM_BTN-1:0] sync_b;

    // Two-flop synchroniser; the channel FSMs only ever look at sync_b
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t              state;
        logic [DB_W-1:0]     count;
        logic [HOLD_W-1:0]   hold_count;
        logic                level_q;
        logic                press_q;
        logic                release_q;
        logic                hold_q;
        logic                s;

        assign s = sync_b[i];

        // Debounce FSM with registered pulses; the hold count is frozen while a
        // release is being qualified so a bounce does not restart the long-hold timer
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state      <= RELEASED;
                count      <= '0;
                hold_count <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                hold_q     <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                // Level follows the state one cycle behind, so it rises the cycle after the press pulse
                level_q   <= (state == PRESSED) || (state == CHK_RELEASE);

                case (state)
                    RELEASED: begin
                        hold_q <= 1'b0;
                        if (s) begin
                            state <= CHK_PRESS;
                            count <= DB_W'(1);
                        end
                    end

                    CHK_PRESS: begin
                        if (!s) begin
                            state <= RELEASED;
                            count <= '0;
                        end else if (count == DB_LAST) begin
                            state   <= PRESSED;
                            press_q <= 1'b1;
                            count   <= '0;
                        end else begin
                            count <= count + DB_W'(1);
                        end
                    end

                    PRESSED: begin
                        if (!s) begin
                            state <= CHK_RELEASE;
                            count <= DB_W'(1);
                        end else if (hold_count != HOLD_MAX) begin
                            hold_count <= hold_count + HOLD_W'(1);
                            hold_q     <= ((hold_count + HOLD_W'(1)) == HOLD_MAX);
                        end
                    end

                    CHK_RELEASE: begin
                        if (s) begin
                            state <= PRESSED;
                            count <= '0;
                        end else if (count == DB_LAST) begin
                            state      <= RELEASED;
                            release_q  <= 1'b1;
                            count      <= '0;
                            hold_count <= '0;
                        end else begin
                            count <= count + DB_W'(1);
                        end
                    end

                    default: begin
                        state <= RELEASED;
                        count <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_hold[i]    = hold_q;
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold windows.
// It uses a vector table for the clean press and hand-written per-cycle
// sequences for bounce, hold, glitch, simultaneous and reset cases.
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int DB = 8;
    localparam int HC = 32;

    localparam logic [3:0] Z = 4'b0000;

    logic       clk;
    logic       reset_n;
    logic [3:0] btn;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_hold;
    logic       any_press;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] hold;
        logic       any;
    } vec_t;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn         (btn),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .any_press   (any_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                            input logic [3:0] rel, input logic [3:0] hld, input logic any);
        chk({tag, ".level"},   btn_level,   lvl);
        chk({tag, ".press"},   btn_press,   prs);
        chk({tag, ".release"}, btn_release, rel);
        chk({tag, ".hold"},    btn_hold,    hld);
        chk({tag, ".any"},     {3'b000, any_press}, {3'b000, any});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t tbl [13];

        reset_n = 1'b1;
        btn     = Z;
        #2 reset_n = 1'b0;
        #1 chk_outs("reset", Z, Z, Z, Z, 1'b0);
        repeat (2) cyc();
        reset_n = 1'b1;

        // Clean press of btn[0]: press pulse at edge 10 after the raw edge, level from edge 11
        for (int k = 0; k < 13; k++) begin
            tbl[k].btn   = 4'b0001;
            tbl[k].level = (k >= 10) ? 4'b0001 : Z;
            tbl[k].press = (k == 9)  ? 4'b0001 : Z;
            tbl[k].rel   = Z;
            tbl[k].hold  = Z;
            tbl[k].any   = (k == 9);
        end
        for (int k = 0; k < 13; k++) begin
            btn = tbl[k].btn;
            cyc();
            chk_outs($sformatf("clean[%0d]", k), tbl[k].level, tbl[k].press,
                     tbl[k].rel, tbl[k].hold, tbl[k].any);
        end

        // Bounce on btn[1]: 3-cycle toggles, final rise at step 18
        btn = Z;
        do_reset();
        for (int t = 0; t < 33; t++) begin
            btn[1] = (t >= 18) ? 1'b1 : (((t / 3) % 2) == 0);
            cyc();
            chk_outs($sformatf("bounce[%0d]", t),
                     (t >= 28) ? 4'b0010 : Z, (t == 27) ? 4'b0010 : Z, Z, Z, (t == 27));
        end

        // Hold and release on btn[2]: raw high for 50 steps
        btn = Z;
        do_reset();
        for (int t = 0; t < 63; t++) begin
            btn[2] = (t < 50);
            cyc();
            chk_outs($sformatf("hold[%0d]", t),
                     (t >= 10 && t <= 59) ? 4'b0100 : Z,
                     (t == 9)  ? 4'b0100 : Z,
                     (t == 59) ? 4'b0100 : Z,
                     (t >= 41 && t <= 59) ? 4'b0100 : Z,
                     (t == 9));
        end

        // Release glitch on btn[3]: 4 low steps; hold count 7 frozen, resumes, reaches 32 at step 46
        btn = Z;
        do_reset();
        for (int t = 0; t < 51; t++) begin
            btn[3] = !(t >= 15 && t <= 18);
            cyc();
            chk_outs($sformatf("glitch[%0d]", t),
                     (t >= 10) ? 4'b1000 : Z,
                     (t == 9)  ? 4'b1000 : Z,
                     Z,
                     (t >= 46) ? 4'b1000 : Z,
                     (t == 9));
        end

        // Simultaneous press of btn[0] and btn[3]
        btn = Z;
        do_reset();
        for (int t = 0; t < 13; t++) begin
            btn = 4'b1001;
            cyc();
            chk_outs($sformatf("simul[%0d]", t),
                     (t >= 10) ? 4'b1001 : Z, (t == 9) ? 4'b1001 : Z, Z, Z, (t == 9));
        end

        // Reset while btn[0] is in CHK_PRESS
        btn = Z;
        do_reset();
        btn = 4'b0001;
        repeat (6) cyc();
        #2 reset_n = 1'b0;
        #1 chk_outs("rst_chk_press", Z, Z, Z, Z, 1'b0);
        repeat (2) cyc();
        reset_n = 1'b1;
        for (int t = 0; t < 46; t++) begin
            cyc();
            chk_outs($sformatf("redebounce[%0d]", t),
                     (t >= 10) ? 4'b0001 : Z, (t == 9) ? 4'b0001 : Z, Z,
                     (t >= 41) ? 4'b0001 : Z, (t == 9));
        end

        // Reset during long hold with the button still held
        #2 reset_n = 1'b0;
        #1 chk_outs("rst_hold", Z, Z, Z, Z, 1'b0);
        repeat (2) cyc();
        chk_outs("rst_hold_held", Z, Z, Z, Z, 1'b0);
        reset_n = 1'b1;
        for (int t = 0; t < 13; t++) begin
            cyc();
            chk_outs($sformatf("after_hold_rst[%0d]", t),
                     (t >= 10) ? 4'b0001 : Z, (t == 9) ? 4'b0001 : Z, Z, Z, (t == 9));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
